move_candidate_loader: RTL and testbench
========================================

MOVE_CANDIDATE_LOADER -- requirements
Module: move_candidate_loader

Interface
REQ-001 SHALL have parameter SLOTS, default 64, meaning the number of candidate slots per frame (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port cand_valid  input  1  candidate present from move evaluator.
REQ-005 SHALL have port cand_score  input  6  candidate score, unsigned.
REQ-006 SHALL have port cand_pos  input  6  candidate board position.
REQ-007 SHALL have port cand_last  input  1  marks final candidate of the frame; qualified by cand_valid.
REQ-008 SHALL have port cand_ready  output  1  loader can accept a candidate this cycle.
REQ-009 SHALL have port frame_ack  input  1  max-tree arbiter consumer has latched the frame.
REQ-010 SHALL have port frame_valid  output  1  slot banks hold a complete, stable frame.
REQ-011 SHALL have port slot_score  output  6*SLOTS  flat score bank; slot i occupies bits [6i+5:6i].
REQ-012 SHALL have port slot_pos  output  6*SLOTS  flat position bank, same packing as slot_score.
REQ-013 SHALL have port slot_count  output  7  number of slots written in the current frame.

Function
REQ-014 SHALL implement a two-state machine: FILL (cand_ready=1, frame_valid=0) and HOLD (cand_ready=0, frame_valid=1).
REQ-015 SHALL accept a candidate on a rising edge where cand_valid && cand_ready; an accepted candidate is written to slot slot_count, and slot_count increments by 1.
REQ-016 SHALL transition FILL->HOLD on the edge that accepts a candidate with cand_last=1, or that brings slot_count to SLOTS; frame_valid is high in the cycle following that edge (latency 1).
REQ-017 SHALL NOT accept candidates in HOLD; cand_valid/cand_last in HOLD are ignored and the producer stalls.
REQ-018 SHALL hold slot_score, slot_pos and slot_count constant throughout HOLD.
REQ-019 SHALL transition HOLD->FILL on the edge where frame_ack=1; on that same edge, all slots clear to score 0, pos 0, and slot_count clears to 0.
REQ-020 SHALL ignore frame_ack while in FILL.
REQ-021 SHALL leave unwritten slots at score 0, pos 0, so they never win a strict-greater comparison against a written nonzero slot.
REQ-022 SHALL, when the SLOTS-th candidate carries cand_last=1, perform a single FILL->HOLD transition; no empty frame follows.
REQ-023 SHALL drive cand_ready combinationally from state only, never from cand_valid.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force state FILL, cand_ready=1, frame_valid=0, slot_count=0, and all slot_score/slot_pos entries to 0.
REQ-025 SHALL, on reset asserted mid-frame or in HOLD, discard the partial or held frame; the first edge after deassertion behaves as the first edge in FILL.

Configuration
REQ-026 SHALL honour macro LOADER_ZERO_SKIP_EN. When it is defined, an accepted candidate with cand_score=0 is consumed (handshake completes) but is not written, and slot_count does not increment. Its cand_last still triggers FILL->HOLD. When the macro is undefined, zero-score candidates are stored like any other candidate.

Verification
REQ-027 SHALL cover this scenario: reset, then 3 candidates (10,5),(20,7),(15,9) with last on the third -> slot_count=3, slots 0..2 match inputs, slots 3..63 are 0, frame_valid rises 1 cycle after the third accept.
REQ-028 SHALL cover this scenario: 64 candidates with no cand_last -> HOLD after the 64th accept, cand_ready=0, a 65th candidate stalls until frame_ack, then lands in slot 0 of the new frame.
REQ-029 SHALL cover this scenario: HOLD with frame_ack held low for 20 cycles under random cand_valid -> banks and slot_count unchanged; frame_ack pulse -> next cycle slot_count=0 and all slots are 0.
REQ-030 SHALL cover this scenario: rst_n pulsed low asynchronously after 5 accepts -> outputs reach reset values before the next edge, and the next frame starts at slot 0.
REQ-031 SHALL cover this scenario: with LOADER_ZERO_SKIP_EN, candidates (0,3),(12,4),(0,5 with last) -> slot_count=1, slot 0=(12,4), HOLD entered. Without the macro -> slot_count=3.
REQ-032 SHALL cover this scenario: frame_ack=1 asserted during FILL with 2 slots written -> no state change, slot_count=2.

Source files
------------

// File: rtl/move_candidate_loader.sv
// Collects move-evaluator candidates into flat score/position slot banks and hands a complete
// frame to the max-tree arbiter. Define LOADER_ZERO_SKIP_EN to drop zero-score candidates.
module move_candidate_loader #(
    parameter int unsigned SLOTS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cand_valid,
    input  logic [5:0]           cand_score,
    input  logic [5:0]           cand_pos,
    input  logic                 cand_last,
    output logic                 cand_ready,
    input  logic                 frame_ack,
    output logic                 frame_valid,
    output logic [6*SLOTS-1:0]   slot_score,
    output logic [6*SLOTS-1:0]   slot_pos,
    output logic [6:0]           slot_count
);

    localparam logic [6:0] SlotsFull = 7'(SLOTS);

    typedef enum logic {StFill, StHold} state_e;

    state_e     state_q, state_d;
    logic [6:0] count_q, count_d;
    logic [5:0] score_q [SLOTS];
    logic [5:0] score_d [SLOTS];
    logic [5:0] pos_q   [SLOTS];
    logic [5:0] pos_d   [SLOTS];
    logic       accept;
    logic       store;

    assign cand_ready  = (state_q == StFill);
    assign frame_valid = (state_q == StHold);
    assign accept      = cand_valid && cand_ready;

`ifdef LOADER_ZERO_SKIP_EN
    // Zero-score candidates complete the handshake but never occupy a slot.
    assign store = accept && (cand_score != 6'd0);
`else
    assign store = accept;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        score_d = score_q;
        pos_d   = pos_q;
        unique case (state_q)
            StFill: begin
                if (store) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (count_q == 7'(i)) begin
                            score_d[i] = cand_score;
                            pos_d[i]   = cand_pos;
                        end
                    end
                    count_d = count_q + 7'd1;
                end
                if (accept && (cand_last || count_d == SlotsFull)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (frame_ack) begin
                    state_d = StFill;
                    count_d = '0;
                    for (int i = 0; i < SLOTS; i++) begin
                        score_d[i] = '0;
                        pos_d[i]   = '0;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            count_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                score_q[i] <= '0;
                pos_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            score_q <= score_d;
            pos_q   <= pos_d;
        end
    end

    assign slot_count = count_q;

    for (genvar g = 0; g < SLOTS; g++) begin : g_flat
        assign slot_score[6*g +: 6] = score_q[g];
        assign slot_pos[6*g +: 6]   = pos_q[g];
    end

endmodule

// File: tb/tb_move_candidate_loader.sv
// Directed bench for move_candidate_loader (SLOTS=64); expectations follow LOADER_ZERO_SKIP_EN.
module tb_move_candidate_loader;

    localparam int SLOTS = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 cand_valid = 1'b0;
    logic [5:0]           cand_score = '0;
    logic [5:0]           cand_pos = '0;
    logic                 cand_last = 1'b0;
    logic                 cand_ready;
    logic                 frame_ack = 1'b0;
    logic                 frame_valid;
    logic [6*SLOTS-1:0]   slot_score;
    logic [6*SLOTS-1:0]   slot_pos;
    logic [6:0]           slot_count;

    int checks = 0;
    int errors = 0;

    move_candidate_loader #(.SLOTS(SLOTS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cand_valid (cand_valid),
        .cand_score (cand_score),
        .cand_pos   (cand_pos),
        .cand_last  (cand_last),
        .cand_ready (cand_ready),
        .frame_ack  (frame_ack),
        .frame_valid(frame_valid),
        .slot_score (slot_score),
        .slot_pos   (slot_pos),
        .slot_count (slot_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] sc(input int i);
        return slot_score[6*i +: 6];
    endfunction

    function automatic logic [5:0] ps(input int i);
        return slot_pos[6*i +: 6];
    endfunction

    task automatic push(input logic [5:0] s, input logic [5:0] p, input logic l);
        @(negedge clk);
        cand_valid = 1'b1;
        cand_score = s;
        cand_pos   = p;
        cand_last  = l;
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values appear without any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(cand_ready), 64'd1);
        check("rst_fvalid", 64'(frame_valid), 64'd0);
        check("rst_count", 64'(slot_count), 64'd0);
        check("rst_banks", 64'(|{slot_score, slot_pos}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-candidate frame with last on the third.
        push(6'd10, 6'd5, 1'b0);
        push(6'd20, 6'd7, 1'b0);
        check("s1_fill_fvalid", 64'(frame_valid), 64'd0);
        push(6'd15, 6'd9, 1'b1);
        check("s1_fvalid", 64'(frame_valid), 64'd1);
        check("s1_ready", 64'(cand_ready), 64'd0);
        check("s1_count", 64'(slot_count), 64'd3);
        check("s1_score_lo", 64'(slot_score[17:0]), 64'({6'd15, 6'd20, 6'd10}));
        check("s1_pos_lo", 64'(slot_pos[17:0]), 64'({6'd9, 6'd7, 6'd5}));
        check("s1_hi_zero", 64'(|{slot_score[6*SLOTS-1:18], slot_pos[6*SLOTS-1:18]}), 64'd0);

        // HOLD with random producer traffic and frame_ack low: nothing moves.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cand_valid = 1'($urandom_range(0, 1));
            cand_score = 6'($urandom_range(0, 63));
            cand_pos   = 6'($urandom_range(0, 63));
            cand_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (c % 5 == 4) begin
                check("hold_count", 64'(slot_count), 64'd3);
                check("hold_score", 64'(slot_score[17:0]), 64'({6'd15, 6'd20, 6'd10}));
                check("hold_pos", 64'(slot_pos[17:0]), 64'({6'd9, 6'd7, 6'd5}));
                check("hold_hi", 64'(|{slot_score[6*SLOTS-1:18], slot_pos[6*SLOTS-1:18]}),
                      64'd0);
            end
        end
        @(negedge clk);
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        frame_ack  = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        check("ack_count", 64'(slot_count), 64'd0);
        check("ack_banks", 64'(|{slot_score, slot_pos}), 64'd0);
        check("ack_ready", 64'(cand_ready), 64'd1);
        check("ack_fvalid", 64'(frame_valid), 64'd0);

        // frame_ack during FILL is ignored.
        push(6'd7, 6'd1, 1'b0);
        push(6'd8, 6'd2, 1'b0);
        @(negedge clk);
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        check("fillack_count", 64'(slot_count), 64'd2);
        check("fillack_fvalid", 64'(frame_valid), 64'd0);
        check("fillack_slot1", 64'({sc(1), ps(1)}), 64'({6'd8, 6'd2}));

        // Asynchronous reset after five accepts.
        push(6'd9, 6'd3, 1'b0);
        push(6'd10, 6'd4, 1'b0);
        push(6'd11, 6'd5, 1'b0);
        check("pre_rst_count", 64'(slot_count), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 64'(slot_count), 64'd0);
        check("arst_banks", 64'(|{slot_score, slot_pos}), 64'd0);
        check("arst_ready", 64'(cand_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        push(6'd33, 6'd1, 1'b0);
        check("post_rst_slot0", 64'({sc(0), ps(0)}), 64'({6'd33, 6'd1}));
        check("post_rst_count", 64'(slot_count), 64'd1);

        // Full frame of SLOTS candidates with no last flag.
        do_reset();
        for (int i = 0; i < SLOTS; i++) begin
            push(6'((i % 63) + 1), 6'(i), 1'b0);
            if (i == SLOTS - 2) check("full_pre_fvalid", 64'(frame_valid), 64'd0);
        end
        check("full_fvalid", 64'(frame_valid), 64'd1);
        check("full_ready", 64'(cand_ready), 64'd0);
        check("full_count", 64'(slot_count), 64'd64);
        for (int i = 0; i < SLOTS; i += 21) begin
            check("full_slot", 64'({sc(i), ps(i)}), 64'({6'((i % 63) + 1), 6'(i)}));
        end
        check("full_slot63", 64'({sc(63), ps(63)}), 64'({6'd1, 6'd63}));
        // A 65th candidate stalls until the frame is acknowledged.
        @(negedge clk);
        cand_valid = 1'b1;
        cand_score = 6'd50;
        cand_pos   = 6'd2;
        repeat (3) @(posedge clk);
        #1;
        check("stall_count", 64'(slot_count), 64'd64);
        check("stall_slot0", 64'({sc(0), ps(0)}), 64'({6'd1, 6'd0}));
        @(negedge clk);
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        check("stall_ack_count", 64'(slot_count), 64'd0);
        check("stall_ack_ready", 64'(cand_ready), 64'd1);
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        check("new_frame_count", 64'(slot_count), 64'd1);
        check("new_frame_slot0", 64'({sc(0), ps(0)}), 64'({6'd50, 6'd2}));

        // Zero-score candidates.
        do_reset();
        push(6'd0, 6'd3, 1'b0);
        push(6'd12, 6'd4, 1'b0);
        push(6'd0, 6'd5, 1'b1);
        check("zero_fvalid", 64'(frame_valid), 64'd1);
`ifdef LOADER_ZERO_SKIP_EN
        check("zero_count", 64'(slot_count), 64'd1);
        check("zero_slot0", 64'({sc(0), ps(0)}), 64'({6'd12, 6'd4}));
        check("zero_slot1", 64'({sc(1), ps(1)}), 64'd0);
`else
        check("zero_count", 64'(slot_count), 64'd3);
        check("zero_slot0", 64'({sc(0), ps(0)}), 64'({6'd0, 6'd3}));
        check("zero_slot1", 64'({sc(1), ps(1)}), 64'({6'd12, 6'd4}));
        check("zero_slot2", 64'({sc(2), ps(2)}), 64'({6'd0, 6'd5}));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
